// File: rtl/mem_block_responder_if.sv
// mem_block_responder_if: block request / refill / write-back bundle between
// the MEM-stage data cache (master) and the main-memory responder (slave).
interface mem_block_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_last;
  logic        busy;
  logic        err;

  // Cache side: issues requests and write-back words, receives refill beats.
  modport master (
    output req_valid, req_write, req_addr, wr_data, wr_valid,
    input  req_ready, wr_ready, rd_data, rd_valid, rd_last, busy, err
  );

  // Memory side: accepts requests, streams refill beats, absorbs write-back words.
  modport slave (
    input  req_valid, req_write, req_addr, wr_data, wr_valid,
    output req_ready, wr_ready, rd_data, rd_valid, rd_last, busy, err
  );
endinterface

// File: rtl/mem_block_responder.sv
// mem_block_responder: main-memory side of the data-cache refill/write-back
// path. Accepts one block request at a time, waits LATENCY cycles, then
// streams WORDS_PER_BLOCK refill words or absorbs WORDS_PER_BLOCK write-back
// words into the backing array.
// Optional feature macro: RANGE_CHECK_EN -- flags requests whose word index
// is >= MEM_WORDS on err, returns zero refill data and drops write-back words
// for them. Without it, addresses wrap modulo MEM_WORDS and err stays 0.
module mem_block_responder #(
  parameter int WORDS_PER_BLOCK = 4,
  parameter int LATENCY         = 8,
  parameter int MEM_WORDS       = 1024
) (
  input  logic                  Clk,
  input  logic                  reset,
  mem_block_responder_if.slave  bus
);

  localparam int KW = $clog2(WORDS_PER_BLOCK);
  localparam int AW = $clog2(MEM_WORDS);
  // The counter only ever holds LATENCY-1 down to 1.
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_RD_XFER = 2'd2,
    S_WR_XFER = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [KW-1:0]   k_q, k_d;
  logic [AW-1:0]   base_q, base_d;
  logic            write_q, write_d;
  logic            err_q, err_d;
  logic            req_ready_q, req_ready_d;
  logic            wr_ready_q, wr_ready_d;
  logic            rd_valid_q, rd_valid_d;
  logic            rd_last_q, rd_last_d;

  logic            go_xfer;
  logic            mem_we;
  logic [AW-1:0]   rd_addr;
  logic [AW-1:0]   wr_addr;
  logic            addr_oor;
  logic [31:0]     ram_rd_q;
  logic [31:0]     mem_q [MEM_WORDS];
  logic            unused_addr;

`ifdef RANGE_CHECK_EN
  assign addr_oor = |bus.req_addr[31:AW+2];
`else
  assign addr_oor = 1'b0;
`endif

  // Byte-offset and in-block offset bits never select anything; upper bits
  // are dropped when addresses wrap.
  assign unused_addr = ^{bus.req_addr[31:AW+2], bus.req_addr[KW+1:0]};

  // Next-state and next-output decode; outputs are all taken from flops.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    k_d         = k_q;
    base_d      = base_q;
    write_d     = write_q;
    err_d       = err_q;
    req_ready_d = req_ready_q;
    wr_ready_d  = wr_ready_q;
    rd_valid_d  = 1'b0;
    go_xfer     = 1'b0;
    mem_we      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          base_d      = {bus.req_addr[AW+1:KW+2], {KW{1'b0}}};
          write_d     = bus.req_write;
          err_d       = addr_oor;
          cnt_d       = CW'(LATENCY - 1);
          k_d         = '0;
          req_ready_d = 1'b0;
          if (LATENCY == 1) go_xfer = 1'b1;
          else              state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        // Leaving as the count reaches zero puts the first beat LATENCY
        // cycles after acceptance.
        if (cnt_q == CW'(1)) go_xfer = 1'b1;
      end
      S_RD_XFER: begin
        if (k_q == K_LAST) begin
          state_d     = S_IDLE;
          req_ready_d = 1'b1;
          k_d         = '0;
        end else begin
          k_d        = k_q + 1'b1;
          rd_valid_d = 1'b1;
        end
      end
      S_WR_XFER: begin
        if (bus.wr_valid) begin
          mem_we = ~err_q;
          if (k_q == K_LAST) begin
            state_d     = S_IDLE;
            wr_ready_d  = 1'b0;
            req_ready_d = 1'b1;
            k_d         = '0;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (go_xfer) begin
      if (write_d) begin
        state_d    = S_WR_XFER;
        wr_ready_d = 1'b1;
      end else begin
        state_d    = S_RD_XFER;
        rd_valid_d = 1'b1;
      end
    end

    rd_last_d = rd_valid_d && (k_d == K_LAST);
  end

  // The array is read one cycle ahead so the word lands with its beat.
  assign rd_addr = {base_d[AW-1:KW], k_d};
  assign wr_addr = {base_q[AW-1:KW], k_q};

  // FSM and output registers, cleared immediately by reset.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      k_q         <= '0;
      base_q      <= '0;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b1;
      wr_ready_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      base_q      <= base_d;
      write_q     <= write_d;
      err_q       <= err_d;
      req_ready_q <= req_ready_d;
      wr_ready_q  <= wr_ready_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
    end
  end

  // Backing array: write port and registered read port, untouched by reset.
  always_ff @(posedge Clk) begin
    if (mem_we)     mem_q[wr_addr] <= bus.wr_data;
    if (rd_valid_d) ram_rd_q       <= mem_q[rd_addr];
  end

  assign bus.req_ready = req_ready_q;
  assign bus.busy      = ~req_ready_q;
  assign bus.wr_ready  = wr_ready_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_last   = rd_last_q;
  assign bus.err       = err_q;
  // Out-of-range refills return zeros; idle cycles always show zero.
  assign bus.rd_data   = (rd_valid_q && !err_q) ? ram_rd_q : 32'h0;

endmodule
